// File: rtl/key_debounce_if.sv
// Key bundle between the raw DE0-Nano buttons and the debounced outputs.
// The debouncer takes the slave side; whoever drives KEY holds the master side.
interface key_debounce_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] KEY_LEVEL;
  logic [NUM_KEYS-1:0] KEY_PRESS;
  logic [NUM_KEYS-1:0] KEY_RELEASE;

  modport master (
    output KEY,
    input  KEY_LEVEL,
    input  KEY_PRESS,
    input  KEY_RELEASE
  );

  modport slave (
    input  KEY,
    output KEY_LEVEL,
    output KEY_PRESS,
    output KEY_RELEASE
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: per key a 2-flop synchroniser and a debounce FSM
// producing a clean pressed level plus one-cycle press/release pulses.
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input logic           CLOCK_50,
  input logic           RESET_N,
  key_debounce_if.slave keyIf
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } debounceState_e;

  localparam logic                 RELEASED_RAW = (KEY_ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 pressed;
    debounceState_e       state_q;
    debounceState_e       state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 level_q;
    logic                 level_d;
    logic                 press_q;
    logic                 press_d;
    logic                 release_q;
    logic                 release_d;

    // Sync flops reset to the released raw level so reset never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        sync1_q <= RELEASED_RAW;
        sync2_q <= RELEASED_RAW;
      end else begin
        sync1_q <= keyIf.KEY[k];
        sync2_q <= sync1_q;
      end
    end

    assign pressed = sync2_q ^ RELEASED_RAW;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // A contrary sample in either WAIT state abandons the attempt; the count
    // is cleared on the next entry, so partial counts never accumulate.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        RELEASED: begin
          if (pressed) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_d = RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
        end
      endcase
    end

    assign keyIf.KEY_LEVEL[k]   = level_q;
    assign keyIf.KEY_PRESS[k]   = press_q;
    assign keyIf.KEY_RELEASE[k] = release_q;
  end

endmodule
